// File: rtl/mem_map_pkg.sv
// Shared definitions for the memory stage: peripheral address map, write-back
// select encodings and timer control bit positions.
package mem_map_pkg;

  localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
  localparam logic [31:0] ADDR_SWITCH  = 32'h4000_0010;
  localparam logic [31:0] ADDR_DIGI    = 32'h4000_0014;
  localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0020;

  typedef enum logic [1:0] {
    MEMTOREG_ALU = 2'b00,
    MEMTOREG_MEM = 2'b01,
    MEMTOREG_PC  = 2'b10
  } memtoreg_e;

  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_IS = 2;
  localparam int unsigned TCON_W  = 3;
  localparam int unsigned DIGI_W  = 12;

  // Word-address match; byte offset bits are never part of the decode.
  function automatic logic word_hit(input logic [29:0] waddr, input logic [29:0] wbase);
    return waddr == wbase;
  endfunction

endpackage

// File: rtl/data_ram.sv
// Data RAM: RAM_WORDS x 32, synchronous write, asynchronous read, with
// in-range decode so out-of-range addresses never alias onto low words.
module data_ram #(
  parameter int unsigned RAM_WORDS = 256
) (
  input  logic        clk,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_hit
);

  localparam int unsigned ADDR_W = $clog2(RAM_WORDS);

  logic [31:0]       r_mem [RAM_WORDS];
  logic [ADDR_W-1:0] w_idx;
  logic              w_unused_addr;

  assign w_idx         = i_addr[ADDR_W+1:2];
  assign o_hit         = (i_addr[31:ADDR_W+2] == '0);
  assign w_unused_addr = ^i_addr[1:0];

  always_ff @(posedge clk) begin
    if (i_we && o_hit) begin
      r_mem[w_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[w_idx];

endmodule

// File: rtl/mem_stage.sv
// Memory / write-back stage: data RAM, memory-mapped timer, LEDs, switches,
// 7-seg and systick, plus the register-file write-back select.
module mem_stage
  import mem_map_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 256,
  parameter int unsigned LED_WIDTH = 8,
  parameter int unsigned SW_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          ALUOut,
  input  logic [31:0]          DataBusB,
  input  logic                 MemRd,
  input  logic                 MemWr,
  input  logic [1:0]           MemToReg,
  input  logic [31:0]          NewPC,
  input  logic [SW_WIDTH-1:0]  switch,
  output logic [31:0]          WriteData,
  output logic [31:0]          ReadData,
  output logic                 interrupt,
  output logic [LED_WIDTH-1:0] led,
  output logic [DIGI_W-1:0]    digi
);

  localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

  logic [31:0]          r_th;
  logic [31:0]          r_tl;
  logic [TCON_W-1:0]    r_tcon;
  logic [LED_WIDTH-1:0] r_led;
  logic [DIGI_W-1:0]    r_digi;
  logic [31:0]          r_systick;
  logic [SW_WIDTH-1:0]  r_sw_meta;
  logic [SW_WIDTH-1:0]  r_sw_sync;

  logic [29:0] w_waddr;
  logic        w_sel_th, w_sel_tl, w_sel_tcon, w_sel_led;
  logic        w_sel_sw, w_sel_digi, w_sel_systick;
  logic        w_wr_th, w_wr_tl, w_wr_tcon;
  logic        w_ram_we, w_ram_hit;
  logic [31:0] w_ram_rdata;
  logic [31:0] w_map_rdata;
  logic        w_tl_wrap;

  assign w_waddr       = ALUOut[31:2];
  assign w_sel_th      = word_hit(w_waddr, ADDR_TH[31:2]);
  assign w_sel_tl      = word_hit(w_waddr, ADDR_TL[31:2]);
  assign w_sel_tcon    = word_hit(w_waddr, ADDR_TCON[31:2]);
  assign w_sel_led     = word_hit(w_waddr, ADDR_LED[31:2]);
  assign w_sel_sw      = word_hit(w_waddr, ADDR_SWITCH[31:2]);
  assign w_sel_digi    = word_hit(w_waddr, ADDR_DIGI[31:2]);
  assign w_sel_systick = word_hit(w_waddr, ADDR_SYSTICK[31:2]);

  assign w_wr_th   = MemWr & w_sel_th;
  assign w_wr_tl   = MemWr & w_sel_tl;
  assign w_wr_tcon = MemWr & w_sel_tcon;

  // A store still in flight when reset rises must not land in the RAM.
  assign w_ram_we = MemWr & ~reset;

  data_ram #(
    .RAM_WORDS (RAM_WORDS)
  ) u_data_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (ALUOut),
    .i_wdata (DataBusB),
    .o_rdata (w_ram_rdata),
    .o_hit   (w_ram_hit)
  );

  assign w_tl_wrap = r_tcon[TCON_EN] && (r_tl == TL_MAX);

  // Timer: CPU writes to TH/TL/TCON take priority over the counting logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_th   <= '0;
      r_tl   <= '0;
      r_tcon <= '0;
    end else begin
      if (w_wr_th) begin
        r_th <= DataBusB;
      end
      if (w_wr_tl) begin
        r_tl <= DataBusB;
      end else if (w_tl_wrap) begin
        r_tl <= r_th;
      end else if (r_tcon[TCON_EN]) begin
        r_tl <= r_tl + 32'd1;
      end
      if (w_wr_tcon) begin
        r_tcon <= DataBusB[TCON_W-1:0];
      end else if (!w_wr_tl && w_tl_wrap && r_tcon[TCON_IE]) begin
        r_tcon[TCON_IS] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led  <= '0;
      r_digi <= '0;
    end else begin
      if (MemWr && w_sel_led) begin
        r_led <= DataBusB[LED_WIDTH-1:0];
      end
      if (MemWr && w_sel_digi) begin
        r_digi <= DataBusB[DIGI_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_systick <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_systick <= r_systick + 32'd1;
      r_sw_meta <= switch;
      r_sw_sync <= r_sw_meta;
    end
  end

  always_comb begin
    w_map_rdata = '0;
    if (w_ram_hit) begin
      w_map_rdata = w_ram_rdata;
    end else if (w_sel_th) begin
      w_map_rdata = r_th;
    end else if (w_sel_tl) begin
      w_map_rdata = r_tl;
    end else if (w_sel_tcon) begin
      w_map_rdata = 32'(r_tcon);
    end else if (w_sel_led) begin
      w_map_rdata = 32'(r_led);
    end else if (w_sel_sw) begin
      w_map_rdata = 32'(r_sw_sync);
    end else if (w_sel_digi) begin
      w_map_rdata = 32'(r_digi);
    end else if (w_sel_systick) begin
      w_map_rdata = r_systick;
    end
  end

  assign ReadData = MemRd ? w_map_rdata : 32'h0;

  always_comb begin
    WriteData = NewPC;
    case (MemToReg)
      MEMTOREG_ALU: WriteData = ALUOut;
      MEMTOREG_MEM: WriteData = ReadData;
      default:      WriteData = NewPC;
    endcase
  end

  assign interrupt = r_tcon[TCON_IS] & r_tcon[TCON_IE];
  assign led       = r_led;
  assign digi      = r_digi;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: expected load/write-back values are queued
// at stimulus time and compared when the DUT output has settled.
module tb_mem_stage;
  import mem_map_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUOut, DataBusB, NewPC;
  logic        MemRd, MemWr;
  logic [1:0]  MemToReg;
  logic [7:0]  switch;
  logic [31:0] WriteData, ReadData;
  logic        interrupt;
  logic [7:0]  led;
  logic [11:0] digi;

  int n_cmp = 0;
  int n_err = 0;

  string       q_tag[$];
  logic [31:0] q_exp[$];
  logic [31:0] m_systick;

  mem_stage #(
    .RAM_WORDS (256),
    .LED_WIDTH (8),
    .SW_WIDTH  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ALUOut    (ALUOut),
    .DataBusB  (DataBusB),
    .MemRd     (MemRd),
    .MemWr     (MemWr),
    .MemToReg  (MemToReg),
    .NewPC     (NewPC),
    .switch    (switch),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .interrupt (interrupt),
    .led       (led),
    .digi      (digi)
  );

  always #5 clk = ~clk;

  // Reference free-running counter for systick.
  always @(posedge clk or posedge reset) begin
    if (reset) m_systick <= 32'd0;
    else       m_systick <= m_systick + 32'd1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    q_tag.push_back(tag);
    q_exp.push_back(exp);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    if (q_tag.size() == 0) begin
      check_eq("sb_underflow", 32'(q_tag.size()), 32'd1);
    end else begin
      check_eq(q_tag.pop_front(), obs, q_exp.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    ALUOut   = addr;
    DataBusB = data;
    MemRd    = 1'b0;
    MemWr    = 1'b1;
    tick();
    MemWr    = 1'b0;
  endtask

  task automatic load(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    ALUOut   = addr;
    MemRd    = 1'b1;
    MemToReg = MEMTOREG_MEM;
    sb_push(tag, exp);
    #1;
    sb_pop(ReadData);
    MemRd    = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    ALUOut   = '0;
    DataBusB = '0;
    NewPC    = '0;
    MemRd    = 1'b0;
    MemWr    = 1'b0;
    MemToReg = MEMTOREG_ALU;
    switch   = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset asserted mid-cycle while the timer counts
    store(ADDR_LED, 32'h0000_00A5);
    store(ADDR_TCON, 32'd3);
    store(ADDR_TL, 32'd5);
    load("tl_pre_rst", ADDR_TL, 32'd5);
    check_eq("led_pre_rst", 32'(led), 32'h0000_00A5);
    #1 reset = 1'b1;
    #1;
    check_eq("rst_led", 32'(led), 32'd0);
    check_eq("rst_digi", 32'(digi), 32'd0);
    check_eq("rst_irq", 32'(interrupt), 32'd0);
    load("rst_tl", ADDR_TL, 32'd0);
    load("rst_tcon", ADDR_TCON, 32'd0);
    load("rst_th", ADDR_TH, 32'd0);
    load("rst_systick", ADDR_SYSTICK, 32'd0);
    reset = 1'b0;
    tick();

    // RAM access, read gating, out-of-range and write-back select
    store(32'h0000_0010, 32'h1234_5678);
    ALUOut = 32'h0000_0010; MemRd = 1'b1; MemToReg = MEMTOREG_MEM;
    sb_push("ram_rd", 32'h1234_5678);
    sb_push("wb_mem", 32'h1234_5678);
    #1;
    sb_pop(ReadData);
    sb_pop(WriteData);
    MemRd = 1'b0;
    sb_push("rd_gated", 32'h0);
    #1;
    sb_pop(ReadData);
    load("ram_oob", 32'h0000_0400, 32'h0);
    store(32'h0000_0000, 32'h1111_1111);
    store(32'h0000_0400, 32'hDEAD_BEEF);
    load("ram_no_alias", 32'h0000_0000, 32'h1111_1111);
    store(32'h0000_03FC, 32'hCAFE_F00D);
    load("ram_top", 32'h0000_03FF, 32'hCAFE_F00D);
    ALUOut = 32'h0000_0010; DataBusB = 32'hAABB_CCDD; MemWr = 1'b1; MemRd = 1'b1;
    sb_push("ram_old", 32'h1234_5678);
    #1;
    sb_pop(ReadData);
    tick();
    MemWr = 1'b0;
    sb_push("ram_new", 32'hAABB_CCDD);
    #1;
    sb_pop(ReadData);
    MemRd = 1'b0;

    // Timer overflow, reload and interrupt clear
    store(ADDR_TH, 32'hFFFF_FFFC);
    store(ADDR_TL, 32'hFFFF_FFFC);
    store(ADDR_TCON, 32'd3);
    load("tl_k", ADDR_TL, 32'hFFFF_FFFC);
    tick(); load("tl_k1", ADDR_TL, 32'hFFFF_FFFD);
    tick(); load("tl_k2", ADDR_TL, 32'hFFFF_FFFE);
    tick(); load("tl_k3", ADDR_TL, 32'hFFFF_FFFF);
    check_eq("irq_k3", 32'(interrupt), 32'd0);
    tick(); load("tl_reload", ADDR_TL, 32'hFFFF_FFFC);
    check_eq("irq_set", 32'(interrupt), 32'd1);
    load("tcon_status", ADDR_TCON, 32'd7);
    store(ADDR_TCON, 32'd3);
    check_eq("irq_clear", 32'(interrupt), 32'd0);

    // TL write on the overflow edge wins over reload and status
    store(ADDR_TL, 32'hFFFF_FFFE);
    tick(); load("tl_at_ff", ADDR_TL, 32'hFFFF_FFFF);
    store(ADDR_TL, 32'h0000_0010);
    load("tl_wr_wins", ADDR_TL, 32'h0000_0010);
    check_eq("irq_tl_coll", 32'(interrupt), 32'd0);
    load("tcon_tl_coll", ADDR_TCON, 32'd3);

    // TCON write on the overflow edge drops the status set
    store(ADDR_TL, 32'hFFFF_FFFE);
    tick();
    store(ADDR_TCON, 32'd3);
    check_eq("irq_tcon_coll", 32'(interrupt), 32'd0);
    load("tcon_coll", ADDR_TCON, 32'd3);
    load("tl_tcon_coll", ADDR_TL, 32'hFFFF_FFFC);
    store(ADDR_TCON, 32'd0);

    // Switch synchroniser latency
    switch = 8'h3C;
    tick(); load("sw_1edge", ADDR_SWITCH, 32'h0000_0000);
    tick(); load("sw_2edge", ADDR_SWITCH, 32'h0000_003C);

    // LED/7-seg registers and unmapped space
    store(ADDR_LED, 32'h0000_01FF);
    check_eq("led_out", 32'(led), 32'h0000_00FF);
    store(ADDR_DIGI, 32'hFFFF_FABC);
    check_eq("digi_out", 32'(digi), 32'h0000_0ABC);
    load("digi_rd", ADDR_DIGI, 32'h0000_0ABC);
    store(32'h4000_0018, 32'h5);
    load("unmapped", 32'h4000_0018, 32'h0);

    // Link write-back and systick
    ALUOut = 32'h0000_1234; NewPC = 32'h0040_0008;
    MemToReg = MEMTOREG_PC;
    sb_push("wb_pc", 32'h0040_0008);
    #1; sb_pop(WriteData);
    MemToReg = 2'b11;
    sb_push("wb_pc11", 32'h0040_0008);
    #1; sb_pop(WriteData);
    MemToReg = MEMTOREG_ALU;
    sb_push("wb_alu", 32'h0000_1234);
    #1; sb_pop(WriteData);
    load("systick_n", ADDR_SYSTICK, m_systick);
    repeat (3) tick();
    load("systick_n3", ADDR_SYSTICK, m_systick);

    check_eq("sb_drained", 32'(q_tag.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
